hazard_ctrl: RTL and testbench

Pipeline sequencing controller that drives the stall and flush inputs of the IF/ID and ID/EX buffers and the PC register. It detects load-use hazards, squashes wrong-path instructions on taken jumps, freezes the pipe on memory wait, and runs the multi-cycle interrupt entry sequence (push PC, push flags, vector). It sits beside the decode stage and reads hazard information from the ID/EX buffer contents.

---
 rtl/hazard_ctrl_pkg.sv | 21 ++
 rtl/hazard_ctrl_if.sv | 42 ++++
 rtl/hazard_ctrl_detect.sv | 27 ++
 rtl/hazard_ctrl.sv | 164 ++++++++++++++++
 tb/tb_hazard_ctrl.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/hazard_ctrl_pkg.sv
// rtl/hazard_ctrl_pkg.sv - shared state encoding and ID/EX field positions for hazard_ctrl
package hazard_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_RUN       = 3'd0,
        ST_BUBBLE    = 3'd1,
        ST_INT_PC    = 3'd2,
        ST_INT_FLAGS = 3'd3,
        ST_INT_VEC   = 3'd4
    } state_t;

    // Bit positions of the hazard-relevant fields inside the ID/EX buffer word
    localparam int IDEX_MR_BIT      = 44;
    localparam int IDEX_WB_BIT      = 46;
    localparam int IDEX_WB_ADDR_MSB = 43;
    localparam int IDEX_WB_ADDR_LSB = 41;

    // Bubble counter only has to hold LOAD_STALL_CYCLES-1, at most 2
    localparam int CNT_W = 2;

endpackage

// File: rtl/hazard_ctrl_if.sv
// rtl/hazard_ctrl_if.sv - hazard information in, pipeline stall/flush controls out
interface hazard_ctrl_if #(
    parameter int REG_ADDR_W = 3
);
    logic [REG_ADDR_W-1:0] id_src1;
    logic [REG_ADDR_W-1:0] id_src2;
    logic                  id_use1;
    logic                  id_use2;
    logic                  ex_mr;
    logic                  ex_wb;
    logic [REG_ADDR_W-1:0] ex_wb_addr;
    logic                  jmp_taken;
    logic                  mem_wait;
    logic                  int_req;

    logic                  pc_stall;
    logic                  if_id_stall;
    logic                  if_id_flush;
    logic                  id_ex_stall;
    logic                  id_ex_flush;
    logic                  inj_stack_pc;
    logic                  inj_stack_flags;
    logic                  pc_load_vec;
    logic                  int_ack;

    // Pipeline side: supplies decode/EX hazard info, consumes controls
    modport master (
        output id_src1, id_src2, id_use1, id_use2,
        output ex_mr, ex_wb, ex_wb_addr, jmp_taken, mem_wait, int_req,
        input  pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush,
        input  inj_stack_pc, inj_stack_flags, pc_load_vec, int_ack
    );

    // Controller side
    modport slave (
        input  id_src1, id_src2, id_use1, id_use2,
        input  ex_mr, ex_wb, ex_wb_addr, jmp_taken, mem_wait, int_req,
        output pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush,
        output inj_stack_pc, inj_stack_flags, pc_load_vec, int_ack
    );

endinterface

// File: rtl/hazard_ctrl_detect.sv
// rtl/hazard_ctrl_detect.sv - combinational load-use hazard compare
module hazard_detect
    import hazard_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W = 3
) (
    input  logic [REG_ADDR_W-1:0] i_id_src1,
    input  logic [REG_ADDR_W-1:0] i_id_src2,
    input  logic                  i_id_use1,
    input  logic                  i_id_use2,
    input  logic                  i_ex_mr,
    input  logic                  i_ex_wb,
    input  logic [REG_ADDR_W-1:0] i_ex_wb_addr,
    output logic                  o_load_use
);

    logic w_hit1;
    logic w_hit2;

    // A load in EX whose destination is read by the instruction in decode
    always_comb begin
        w_hit1     = i_id_use1 && (i_id_src1 == i_ex_wb_addr);
        w_hit2     = i_id_use2 && (i_id_src2 == i_ex_wb_addr);
        o_load_use = i_ex_mr && i_ex_wb && (w_hit1 || w_hit2);
    end

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline stall/flush sequencer with interrupt entry
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W        = 3,
    parameter int LOAD_STALL_CYCLES = 1
) (
    input  logic         clk,
    input  logic         reset,
    hazard_ctrl_if.slave bus
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LOAD_STALL_CYCLES - 1);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_int_pending;
    logic             r_int_req_q;

    state_t           w_next_state;
    logic [CNT_W-1:0] w_cnt_next;
    logic             w_pending_next;
    logic             w_req_q_next;
    logic             w_load_use;
    logic             w_rise;

    logic w_pc_stall, w_if_id_stall, w_if_id_flush, w_id_ex_stall, w_id_ex_flush;
    logic w_inj_pc, w_inj_flags, w_load_vec, w_int_ack;

    hazard_detect #(
        .REG_ADDR_W (REG_ADDR_W)
    ) u_detect (
        .i_id_src1    (bus.id_src1),
        .i_id_src2    (bus.id_src2),
        .i_id_use1    (bus.id_use1),
        .i_id_use2    (bus.id_use2),
        .i_ex_mr      (bus.ex_mr),
        .i_ex_wb      (bus.ex_wb),
        .i_ex_wb_addr (bus.ex_wb_addr),
        .o_load_use   (w_load_use)
    );

    assign w_rise = bus.int_req && !r_int_req_q;

    // State, bubble counter, pending interrupt and int_req history
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= ST_RUN;
            r_cnt         <= '0;
            r_int_pending <= 1'b0;
            r_int_req_q   <= 1'b0;
        end else begin
            r_state       <= w_next_state;
            r_cnt         <= w_cnt_next;
            r_int_pending <= w_pending_next;
            r_int_req_q   <= w_req_q_next;
        end
    end

    // Next-state: mem_wait freezes everything (including edge history so no edge is lost)
    always_comb begin
        w_next_state   = r_state;
        w_cnt_next     = r_cnt;
        w_pending_next = r_int_pending || w_rise;
        w_req_q_next   = bus.int_req;
        if (bus.mem_wait) begin
            w_pending_next = r_int_pending;
            w_req_q_next   = r_int_req_q;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (bus.jmp_taken) begin
                        w_cnt_next = '0;
                    end else if (w_load_use) begin
                        w_cnt_next   = CNT_LOAD;
                        w_next_state = (CNT_LOAD == '0) ? ST_RUN : ST_BUBBLE;
                    end else if (r_int_pending) begin
                        w_next_state   = ST_INT_PC;
                        w_pending_next = w_rise;
                    end
                end
                ST_BUBBLE: begin
                    if (bus.jmp_taken) begin
                        w_cnt_next   = '0;
                        w_next_state = ST_RUN;
                    end else begin
                        w_cnt_next   = (r_cnt == '0) ? '0 : r_cnt - 1'b1;
                        w_next_state = (r_cnt <= CNT_W'(1)) ? ST_RUN : ST_BUBBLE;
                    end
                end
                ST_INT_PC:    w_next_state = ST_INT_FLAGS;
                ST_INT_FLAGS: w_next_state = ST_INT_VEC;
                ST_INT_VEC:   w_next_state = ST_RUN;
                default: begin
                    w_next_state = ST_RUN;
                    w_cnt_next   = '0;
                end
            endcase
        end
    end

    // Outputs: stall and flush on one buffer are mutually exclusive by construction
    always_comb begin
        w_pc_stall    = 1'b0;
        w_if_id_stall = 1'b0;
        w_if_id_flush = 1'b0;
        w_id_ex_stall = 1'b0;
        w_id_ex_flush = 1'b0;
        w_inj_pc      = 1'b0;
        w_inj_flags   = 1'b0;
        w_load_vec    = 1'b0;
        w_int_ack     = 1'b0;
        if (!reset) begin
            w_pc_stall = 1'b0;
        end else if (bus.mem_wait) begin
            w_pc_stall    = 1'b1;
            w_if_id_stall = 1'b1;
            w_id_ex_stall = 1'b1;
        end else begin
            case (r_state)
                ST_RUN, ST_BUBBLE: begin
                    if (bus.jmp_taken) begin
                        w_if_id_flush = 1'b1;
                        w_id_ex_flush = 1'b1;
                    end else if (w_load_use || r_state == ST_BUBBLE) begin
                        w_pc_stall    = 1'b1;
                        w_if_id_stall = 1'b1;
                        w_id_ex_flush = 1'b1;
                    end
                end
                ST_INT_PC: begin
                    w_inj_pc      = 1'b1;
                    w_pc_stall    = 1'b1;
                    w_if_id_flush = 1'b1;
                    w_id_ex_flush = bus.jmp_taken;
                end
                ST_INT_FLAGS: begin
                    w_inj_flags   = 1'b1;
                    w_pc_stall    = 1'b1;
                    w_if_id_flush = 1'b1;
                    w_id_ex_flush = bus.jmp_taken;
                end
                ST_INT_VEC: begin
                    w_load_vec    = 1'b1;
                    w_if_id_flush = 1'b1;
                    w_int_ack     = 1'b1;
                    w_id_ex_flush = bus.jmp_taken;
                end
                default: w_pc_stall = 1'b0;
            endcase
        end
    end

    assign bus.pc_stall        = w_pc_stall;
    assign bus.if_id_stall     = w_if_id_stall;
    assign bus.if_id_flush     = w_if_id_flush;
    assign bus.id_ex_stall     = w_id_ex_stall;
    assign bus.id_ex_flush     = w_id_ex_flush;
    assign bus.inj_stack_pc    = w_inj_pc;
    assign bus.inj_stack_flags = w_inj_flags;
    assign bus.pc_load_vec     = w_load_vec;
    assign bus.int_ack         = w_int_ack;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - scoreboard bench for hazard_ctrl with directed vectors
module tb_hazard_ctrl;

    // Expected vector bit order:
    // {pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush,
    //  inj_stack_pc, inj_stack_flags, pc_load_vec, int_ack}
    localparam logic [8:0] NONE  = 9'b000_000_000;
    localparam logic [8:0] LU    = 9'b110_010_000;
    localparam logic [8:0] JMP   = 9'b001_010_000;
    localparam logic [8:0] MW    = 9'b110_100_000;
    localparam logic [8:0] IPC   = 9'b101_001_000;
    localparam logic [8:0] IPCJ  = 9'b101_011_000;
    localparam logic [8:0] IFL   = 9'b101_000_100;
    localparam logic [8:0] IVEC  = 9'b001_000_011;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   tests = 0;
    int   fails = 0;

    logic [8:0] exp_q[$];
    string      name_q[$];

    always #5 clk = ~clk;

    hazard_ctrl_if #(.REG_ADDR_W(3)) hif ();

    hazard_ctrl #(
        .REG_ADDR_W        (3),
        .LOAD_STALL_CYCLES (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (hif.slave)
    );

    task automatic clear_inputs();
        hif.id_src1    = 3'd0;
        hif.id_src2    = 3'd0;
        hif.id_use1    = 1'b0;
        hif.id_use2    = 1'b0;
        hif.ex_mr      = 1'b0;
        hif.ex_wb      = 1'b0;
        hif.ex_wb_addr = 3'd0;
        hif.jmp_taken  = 1'b0;
        hif.mem_wait   = 1'b0;
    endtask

    task automatic set_hazard1();
        hif.ex_mr      = 1'b1;
        hif.ex_wb      = 1'b1;
        hif.ex_wb_addr = 3'd3;
        hif.id_src1    = 3'd3;
        hif.id_use1    = 1'b1;
    endtask

    // Queue the expectation for the current cycle, then advance one clock
    task automatic cyc(input logic [8:0] exp, input string nm);
        exp_q.push_back(exp);
        name_q.push_back(nm);
        @(posedge clk);
        #1;
    endtask

    // Monitor: the controller presents its outputs every cycle; compare mid-cycle
    initial begin
        logic [8:0] act;
        logic [8:0] exp;
        string      nm;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                exp = exp_q.pop_front();
                nm  = name_q.pop_front();
                act = {hif.pc_stall, hif.if_id_stall, hif.if_id_flush, hif.id_ex_stall,
                       hif.id_ex_flush, hif.inj_stack_pc, hif.inj_stack_flags,
                       hif.pc_load_vec, hif.int_ack};
                tests++;
                if (act !== exp) begin
                    fails++;
                    $display("FAIL %s: got %b expected %b", nm, act, exp);
                end
            end
        end
    end

    initial begin
        clear_inputs();
        hif.int_req = 1'b0;
        @(posedge clk);
        #1;

        // Reset: outputs forced low even with hazard and jump active
        set_hazard1();
        hif.jmp_taken = 1'b1;
        cyc(NONE, "reset_outputs");
        clear_inputs();
        reset = 1'b1;
        cyc(NONE, "idle");

        // Load-use on src1: exactly two stall cycles
        set_hazard1();
        cyc(LU, "lu1_c0");
        cyc(LU, "lu1_c1");
        hif.ex_mr = 1'b0;
        cyc(NONE, "lu1_done");

        // Load-use on src2
        clear_inputs();
        hif.ex_mr = 1'b1; hif.ex_wb = 1'b1; hif.ex_wb_addr = 3'd5;
        hif.id_src2 = 3'd5; hif.id_use2 = 1'b1; hif.id_src1 = 3'd5;
        cyc(LU, "lu2_c0");
        hif.ex_mr = 1'b0;
        cyc(LU, "lu2_c1");
        cyc(NONE, "lu2_done");

        // Address match but operand unused, or EX not writing back: no hazard
        clear_inputs();
        hif.ex_mr = 1'b1; hif.ex_wb = 1'b1; hif.ex_wb_addr = 3'd3; hif.id_src1 = 3'd3;
        cyc(NONE, "no_use");
        set_hazard1();
        hif.ex_wb = 1'b0;
        cyc(NONE, "no_wb");

        // Jump overrides load-use; next cycle must be plain RUN
        set_hazard1();
        hif.jmp_taken = 1'b1;
        cyc(JMP, "lu_plus_jmp");
        clear_inputs();
        cyc(NONE, "after_jmp_run");

        // mem_wait dominates hazard and jump
        set_hazard1();
        hif.mem_wait = 1'b1;
        cyc(MW, "mw_over_lu");
        hif.jmp_taken = 1'b1;
        cyc(MW, "mw_over_jmp");
        clear_inputs();

        // Interrupt entry in idle pipe, then held level gives no re-entry
        hif.int_req = 1'b1;
        cyc(NONE, "int_edge");
        cyc(NONE, "int_entry");
        cyc(IPC,  "int_pc");
        cyc(IFL,  "int_flags");
        cyc(IVEC, "int_vec");
        cyc(NONE, "int_back_run");
        cyc(NONE, "int_held_1");
        cyc(NONE, "int_held_2");

        // mem_wait for 4 cycles inside INT_FLAGS, jump during INT_PC
        hif.int_req = 1'b0;
        cyc(NONE, "mw_int_low");
        hif.int_req = 1'b1;
        cyc(NONE, "mw_int_edge");
        cyc(NONE, "mw_int_entry");
        hif.jmp_taken = 1'b1;
        cyc(IPCJ, "mw_int_pc_jmp");
        hif.jmp_taken = 1'b0;
        hif.mem_wait = 1'b1;
        for (int i = 0; i < 4; i++) cyc(MW, "mw_int_hold");
        hif.mem_wait = 1'b0;
        cyc(IFL,  "mw_int_flags");
        cyc(IVEC, "mw_int_vec");
        cyc(NONE, "mw_int_run");

        // Edge during load-use stall: entry deferred until the bubble ends
        hif.int_req = 1'b0;
        cyc(NONE, "def_low");
        set_hazard1();
        hif.int_req = 1'b1;
        cyc(LU, "def_lu_c0");
        cyc(LU, "def_lu_c1");
        clear_inputs();
        cyc(NONE, "def_entry");
        cyc(IPC,  "def_pc");
        cyc(IFL,  "def_flags");
        cyc(IVEC, "def_vec");
        cyc(NONE, "def_run");
        cyc(NONE, "def_no_reentry");

        // Reset during INT_PC aborts the sequence
        hif.int_req = 1'b0;
        cyc(NONE, "rst_low");
        hif.int_req = 1'b1;
        cyc(NONE, "rst_edge");
        cyc(NONE, "rst_entry");
        reset = 1'b0;
        hif.int_req = 1'b0;
        cyc(NONE, "rst_in_int_pc");
        reset = 1'b1;
        cyc(NONE, "rst_after_1");
        cyc(NONE, "rst_after_2");
        cyc(NONE, "rst_after_3");
        set_hazard1();
        cyc(LU, "rst_run_lu");
        clear_inputs();

        repeat (3) @(posedge clk);
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
